// File: rtl/queue_pkg.sv
// rtl/queue_pkg.sv - shared reader state type and queue geometry defaults
package queue_pkg;

    // Geometry shared with the upstream queue instance
    localparam int QUEUE_ADDR = 5;
    localparam int QUEUE_DATA = 42;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

endpackage

// File: rtl/flush_timer.sv
// rtl/flush_timer.sv - saturating idle counter with synchronous clear
module flush_timer #(
    parameter int TIMEOUT = 16,
    parameter int W       = $clog2(TIMEOUT + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    localparam logic [W-1:0] SAT = W'(TIMEOUT);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over increment; counting stops once TIMEOUT is reached
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != SAT)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/queue_burst_reader.sv
// rtl/queue_burst_reader.sv - drains an upstream queue into length-tagged bursts
module queue_burst_reader
    import queue_pkg::*;
#(
    parameter int ADDR    = QUEUE_ADDR,
    parameter int DATA    = QUEUE_DATA,
    parameter int BURST   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            q_empty,
    input  logic [ADDR:0]   q_count,
    input  logic [DATA-1:0] q_rdata,
    output logic            q_ren,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [DATA-1:0] m_data,
    output logic            m_last,
    output logic [ADDR:0]   m_len,
    output logic            busy
);

    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam int            FLUSH_AT_I = TIMEOUT - 1;
    localparam logic [TW-1:0] FLUSH_AT   = FLUSH_AT_I[TW-1:0];
    localparam logic [ADDR:0] BURST_LEN  = BURST[ADDR:0];

    state_e          state_q, state_d;
    logic [ADDR:0]   rem_q, rem_d;
    logic [ADDR:0]   len_q, len_d;
    logic [DATA-1:0] data_q, data_d;
    logic            valid_q, valid_d;
    logic            last_q, last_d;

    logic [TW-1:0]   timer;
    logic            pop;
    logic            accept;
    logic            go_burst;
    logic            go_flush;
    logic            timer_inc;
    logic            timer_clr;

    // Idle timer: runs only while IDLE with data waiting, cleared once a burst starts
    flush_timer #(
        .TIMEOUT (TIMEOUT),
        .W       (TW)
    ) u_flush_timer (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (timer_clr),
        .inc_i   (timer_inc),
        .count_o (timer)
    );

    // Next-state, burst bookkeeping and pop request; full bursts beat timeout flushes
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        len_d   = len_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;

        pop      = (state_q == STREAM) && (rem_q != '0) && !q_empty &&
                   (!valid_q || m_ready) && !rst;
        accept   = valid_q && m_ready;
        go_burst = (state_q == IDLE) && (q_count >= BURST_LEN);
        go_flush = (state_q == IDLE) && !go_burst && (q_count != '0) &&
                   (timer == FLUSH_AT);

        timer_inc = (state_q == IDLE) && (q_count != '0);
        timer_clr = (state_q != IDLE) || (q_count == '0) || go_burst || go_flush;

        case (state_q)
            IDLE: begin
                if (go_burst) begin
                    state_d = STREAM;
                    len_d   = BURST_LEN;
                    rem_d   = BURST_LEN;
                end else if (go_flush) begin
                    state_d = STREAM;
                    len_d   = q_count;
                    rem_d   = q_count;
                end
            end
            STREAM: begin
                if (pop) begin
                    data_d  = q_rdata;
                    valid_d = 1'b1;
                    last_d  = (rem_q == {{ADDR{1'b0}}, 1'b1});
                    rem_d   = rem_q - 1'b1;
                end else if (accept) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
                if (accept && last_q) begin
                    state_d = IDLE;
                    len_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Output word and burst counters; reset drops any word in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            rem_q   <= rem_d;
            len_q   <= len_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign q_ren   = pop;
    assign m_valid = valid_q;
    assign m_data  = data_q;
    assign m_last  = last_q;
    assign m_len   = len_q;
    assign busy    = (state_q == STREAM);

endmodule

// File: tb/tb_queue_burst_reader.sv
// tb/tb_queue_burst_reader.sv - directed and random checks against a queue/scoreboard model
module tb_queue_burst_reader;

    localparam int ADDR    = 5;
    localparam int DATA    = 42;
    localparam int BURST   = 8;
    localparam int TIMEOUT = 16;
    localparam int DEPTH   = 1 << ADDR;

    logic            clk = 1'b0;
    logic            rst;
    logic            q_empty;
    logic [ADDR:0]   q_count;
    logic [DATA-1:0] q_rdata;
    logic            q_ren;
    logic            m_valid;
    logic            m_ready;
    logic [DATA-1:0] m_data;
    logic            m_last;
    logic [ADDR:0]   m_len;
    logic            busy;

    queue_burst_reader #(
        .ADDR    (ADDR),
        .DATA    (DATA),
        .BURST   (BURST),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .q_empty (q_empty),
        .q_count (q_count),
        .q_rdata (q_rdata),
        .q_ren   (q_ren),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_len   (m_len),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    logic [DATA-1:0] fifo[$];
    logic [DATA-1:0] sb[$];
    int              burst_lens[$];

    int n_vec = 0;
    int n_err = 0;

    int              pops_in_burst = 0;
    int              acc_in_burst  = 0;
    int              pops_total    = 0;
    int              ren_run       = 0;
    int              ren_run_max   = 0;
    bit              in_burst      = 0;
    int              cur_len       = 0;
    bit              prev_valid    = 0;
    bit              prev_ready    = 0;
    bit              prev_pop      = 0;
    logic [DATA-1:0] prev_data     = '0;
    logic [DATA-1:0] prev_word     = '0;
    bit              prev_last     = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic update_q();
        q_count = (ADDR + 1)'(fifo.size());
        q_empty = (fifo.size() == 0);
        q_rdata = (fifo.size() == 0) ? '0 : fifo[0];
    endtask

    task automatic push_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        if (fifo.size() < DEPTH) begin
            fifo.push_back(r[DATA-1:0]);
            sb.push_back(r[DATA-1:0]);
        end
        update_q();
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) push_word();
    endtask

    // One clock: called just after a falling edge with inputs already driven
    task automatic tick();
        bit              do_pop;
        logic [DATA-1:0] ew;
        logic [DATA-1:0] pw;
        #1;
        if (prev_pop) begin
            chk("pop_to_valid", m_valid, 1);
            chk("pop_data", m_data, prev_word);
        end
        if (prev_valid && !prev_ready) begin
            chk("stall_valid", m_valid, 1);
            chk("stall_data", m_data, prev_data);
            chk("stall_last", m_last, prev_last);
        end
        if (q_ren) chk("ren_nonempty", q_empty, 0);
        if (m_valid && !m_ready) chk("ren_stall", q_ren, 0);
        if (busy && !in_burst) begin
            in_burst = 1;
            cur_len  = int'(m_len);
            chk("len_range", (cur_len >= 1) && (cur_len <= BURST), 1);
        end else if (busy) begin
            chk("len_stable", m_len, cur_len);
        end else begin
            chk("len_idle", m_len, 0);
        end
        do_pop = q_ren;
        pw     = (fifo.size() > 0) ? fifo[0] : '0;
        if (do_pop) begin
            pops_in_burst++;
            pops_total++;
            chk("pop_bound", pops_in_burst <= cur_len, 1);
            ren_run++;
            if (ren_run > ren_run_max) ren_run_max = ren_run;
        end else begin
            ren_run = 0;
        end
        if (m_valid && m_ready) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                ew = sb.pop_front();
                chk("data", m_data, ew);
            end
            acc_in_burst++;
            chk("last", m_last, acc_in_burst == cur_len);
            if (m_last) begin
                chk("pops_per_burst", pops_in_burst, cur_len);
                burst_lens.push_back(cur_len);
                pops_in_burst = 0;
                acc_in_burst  = 0;
                in_burst      = 0;
            end
        end
        prev_valid = m_valid;
        prev_ready = m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        prev_pop   = do_pop;
        prev_word  = pw;
        @(posedge clk);
        #1;
        if (do_pop && (fifo.size() > 0)) void'(fifo.pop_front());
        update_q();
        @(negedge clk);
    endtask

    // Words popped but never accepted are lost by design; drop them from the scoreboard
    task automatic do_reset(input int n);
        int drop;
        drop = pops_in_burst - acc_in_burst;
        for (int i = 0; i < drop; i++) if (sb.size() > 0) void'(sb.pop_front());
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            chk("ren_in_reset", q_ren, 0);
            @(posedge clk);
            #1;
            @(negedge clk);
        end
        rst = 1'b0;
        pops_in_burst = 0;
        acc_in_burst  = 0;
        in_burst      = 0;
        prev_valid    = 0;
        prev_pop      = 0;
        ren_run       = 0;
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_m_len", m_len, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_q_ren", q_ren, 0);
    endtask

    task automatic drain(input int limit);
        int i;
        i = 0;
        m_ready = 1'b1;
        while (((sb.size() != 0) || busy) && (i < limit)) begin
            tick();
            i++;
        end
        chk("drain_done", (sb.size() == 0) && !busy, 1);
    endtask

    initial begin
        int nb;
        int idle_ticks;
        int bt;
        int guard;
        bit b;

        rst     = 1'b1;
        m_ready = 1'b0;
        update_q();
        @(negedge clk);
        do_reset(3);

        // Full burst of eight with downstream always ready
        m_ready = 1'b1;
        ren_run_max = 0;
        nb = burst_lens.size();
        push_n(8);
        drain(100);
        chk("s1_ren_run", ren_run_max, 8);
        chk("s1_bursts", burst_lens.size(), nb + 1);
        if (burst_lens.size() > nb) chk("s1_len", burst_lens[nb], 8);

        // Partial burst of three flushed by the idle timer
        push_n(3);
        idle_ticks = 0;
        guard = 0;
        while (!busy && (guard < 100)) begin
            tick();
            idle_ticks++;
            guard++;
        end
        chk("s2_idle_ticks", idle_ticks, TIMEOUT);
        nb = burst_lens.size();
        drain(100);
        if (burst_lens.size() > nb) chk("s2_len", burst_lens[nb], 3);
        else chk("s2_burst_seen", burst_lens.size(), nb + 1);

        // Downstream stall during cycles 2-4 of an eight-word burst
        pops_total = 0;
        nb = burst_lens.size();
        push_n(8);
        bt = 0;
        guard = 0;
        while (((sb.size() != 0) || busy) && (guard < 200)) begin
            b = busy;
            m_ready = !(b && (bt >= 2) && (bt <= 4));
            tick();
            if (b) bt++;
            guard++;
        end
        m_ready = 1'b1;
        chk("s3_done", sb.size(), 0);
        chk("s3_pops", pops_total, 8);
        chk("s3_busy_cycles", bt, 8 + 1 + 3);

        // Twenty queued words split into 8, 8 and a timed-out 4
        nb = burst_lens.size();
        push_n(20);
        drain(300);
        chk("s4_bursts", burst_lens.size(), nb + 3);
        if (burst_lens.size() >= nb + 3) begin
            chk("s4_len0", burst_lens[nb], 8);
            chk("s4_len1", burst_lens[nb + 1], 8);
            chk("s4_len2", burst_lens[nb + 2], 4);
        end

        // Reset after the third accepted word abandons the burst
        push_n(8);
        guard = 0;
        m_ready = 1'b1;
        while (!((acc_in_burst == 3) && in_burst) && (guard < 100)) begin
            tick();
            guard++;
        end
        chk("s5_reached", acc_in_burst, 3);
        do_reset(1);
        chk("s5_fifo_left", fifo.size(), 4);
        nb = burst_lens.size();
        drain(200);
        if (burst_lens.size() > nb) chk("s5_len", burst_lens[nb], 4);
        else chk("s5_burst_seen", burst_lens.size(), nb + 1);

        // Random pushes and back-pressure
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) push_n($urandom_range(1, 3));
            m_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(600);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish observed=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/queue_burst_reader.md
QUEUE_BURST_READER -- requirements
Module: queue_burst_reader

Interface
REQ-001 SHALL have parameter ADDR, default 5, meaning upstream queue address width (queue depth 2^ADDR).
REQ-002 SHALL have parameter DATA, default 42, meaning word width.
REQ-003 SHALL have parameter BURST, default 8, meaning maximum words per burst (1..2^ADDR).
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning idle cycles before a partial flush (>=1).
REQ-005 clk  input  1  clock; all state updates on posedge clk.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 q_empty  input  1  upstream queue empty flag.
REQ-008 q_count  input  ADDR+1  upstream queue occupancy.
REQ-009 q_rdata  input  DATA  upstream head word (combinational read).
REQ-010 q_ren  output  1  pop request to upstream queue.
REQ-011 m_valid  output  1  output word valid.
REQ-012 m_ready  input  1  downstream accept.
REQ-013 m_data  output  DATA  output word.
REQ-014 m_last  output  1  marks final word of a burst.
REQ-015 m_len  output  ADDR+1  length of current burst, stable for the whole burst.
REQ-016 busy  output  1  high while state is STREAM.

Function
REQ-017 FSM SHALL have two states: IDLE, STREAM.
REQ-018 Flush timer SHALL count up each IDLE cycle with q_count>0, saturate at TIMEOUT, clear when q_count==0 or on leaving IDLE.
REQ-019 IDLE->STREAM SHALL occur when q_count>=BURST (m_len<=BURST) or, failing that, when q_count>0 and timer==TIMEOUT-1 (m_len<=q_count); BURST threshold has priority.
REQ-020 On entry to STREAM, remaining counter SHALL load m_len.
REQ-021 q_ren SHALL be combinational: state==STREAM && remaining>0 && !q_empty && (!m_valid || m_ready) && !rst.
REQ-022 On a pop SHALL register m_data<=q_rdata, m_valid<=1, m_last<=(remaining==1), remaining<=remaining-1; latency q_ren to m_valid is exactly 1 cycle.
REQ-023 Pop and downstream accept in the same cycle SHALL be allowed; sustained throughput 1 word/cycle with m_ready held high.
REQ-024 m_valid SHALL clear after an accept with no simultaneous pop; m_data/m_last SHALL hold stable while m_valid && !m_ready.
REQ-025 STREAM->IDLE SHALL occur on the cycle m_valid && m_ready && m_last; m_len SHALL then return to 0.
REQ-026 q_empty mid-burst SHALL stall popping without error; burst resumes when data reappears.
REQ-027 Block SHALL never pop more than m_len words per burst, nor pop when q_empty.
REQ-028 Counter arithmetic SHALL use ADDR+1 bits; no wrap of remaining below 0.

Reset
REQ-029 With rst high at posedge: state<=IDLE, timer<=0, remaining<=0, m_valid<=0, m_last<=0, m_len<=0, m_data<=0, busy low.
REQ-030 q_ren SHALL be 0 in any cycle rst is high.
REQ-031 Reset mid-burst SHALL abandon the burst; words already popped are discarded, none re-read.

Structure
REQ-032 Shared package queue_pkg SHALL hold the state typedef (IDLE, STREAM) and default ADDR/DATA constants shared with the queue.
REQ-033 One sub-module flush_timer (saturating idle counter with clear) SHALL be instantiated; rest is single-module RTL.

Verification
REQ-034 Queue loaded with 8 words A0..A7, m_ready=1 -> q_ren high 8 consecutive cycles, m_data A0..A7 one per cycle, m_last only on A7, m_len=8.
REQ-035 3 words in queue, no further writes, TIMEOUT=16 -> burst starts after 16 idle cycles, m_len=3, m_last on third word.
REQ-036 8-word burst, m_ready low cycles 2-4 -> q_ren low while stalled, m_data held, no word lost or duplicated.
REQ-037 20 words queued, BURST=8 -> bursts of 8, 8, then 4 after timeout; 20 words total in order.
REQ-038 rst asserted after 3rd word of 8-word burst -> next cycle m_valid=0, busy=0, q_ren=0; following burst starts from next queue word.
REQ-039 Formal checks: q_ren implies !q_empty; words popped per burst == m_len; m_data stable under stall.
